sw_debounce: RTL
================

// Module: sw_debounce
// PURPOSE
//  Upstream conditioning stage for the seven-segment decoder: takes the raw 16 board slide
//  switches and presents a synchronised, debounced 16-bit value on sw_db. sw_db drives the
//  decoder's sw input directly. Removes metastability and contact bounce, and pulses
//  sw_chg for one cycle whenever any debounced bit changes.
// PARAMETERS
//  WIDTH      16         number of switch bits
//  DB_CYCLES  1_000_000  consecutive stable clk cycles required to accept a new level
//                        (10 ms at 100 MHz); legal range >= 2
//  CNT_W      $clog2(DB_CYCLES+1)  localparam, per-bit counter width
// PORTS
//  clk       in   1      system clock, 100 MHz board clock
//  rst_n     in   1      asynchronous, active-low reset
//  sw_raw    in   WIDTH  raw switch pins, asynchronous to clk
//  sw_db     out  WIDTH  debounced switch value, feeds decoder sw input
//  sw_chg    out  1      one-cycle pulse: sw_db changed this cycle
//  hold      in   1      only with SW_HOLD_EN: freeze sw_db
// BEHAVIOUR
//  - Reset (rst_n=0, async assert; release takes effect on the next clk edge):
//    both sync stages=0, all counters=0, sw_db=0, sw_chg=0.
//  - Sync: 2-flop synchroniser per bit, sw_raw -> s1 -> s2. No logic between stages.
//  - Per-bit debounce counter cnt[i]:
//      s2[i]==sw_db[i]                 -> cnt[i]<=0
//      s2[i]!=sw_db[i], cnt<DB_CYCLES-1 -> cnt[i]<=cnt[i]+1
//      s2[i]!=sw_db[i], cnt==DB_CYCLES-1 -> sw_db[i]<=s2[i], cnt[i]<=0
//  - A glitch shorter than DB_CYCLES cycles at s2 restarts the count. It never reaches sw_db.
//  - Latency: a clean level change at sw_raw appears on sw_db exactly 2+DB_CYCLES clk edges
//    later.
//  - Bits are independent. Several bits may update in the same cycle. sw_chg is the OR of
//    per-bit updates, registered so it is coincident with the sw_db change. Back-to-back
//    changes give back-to-back pulses.
//  - Counters saturate by construction: they never exceed DB_CYCLES-1 and never wrap.
//  - Reset mid-count discards all partial counts. After release, sw_db=0 until each set
//    switch has been stable for DB_CYCLES cycles.
//  - No combinational path from sw_raw to any output.
// CONFIGURATION
//  SW_HOLD_EN defined:
//    - Port hold exists.
//    - While hold=1: sw_db and sw_chg are held (sw_chg=0), all cnt are forced to 0, and the
//      sync stages keep running.
//    - After hold falls, a pending difference must be stable a full DB_CYCLES before it is
//      accepted.
//  SW_HOLD_EN undefined:
//    - Port hold does not exist.
//    - Behaviour is as above with hold treated as 0.
// TESTING  (bench overrides DB_CYCLES=4)
//  1 Reset: rst_n=0 with sw_raw=16'hFFFF -> sw_db=0, sw_chg=0. Both outputs stay 0 while
//    rst_n stays low.
//  2 Clean edge: sw_raw 0->16'h00A5 held -> sw_db=16'h00A5 exactly 6 edges later, with
//    sw_chg=1 for that one cycle only.
//  3 Bounce: bit0 toggles 1,0,1,0 every 2 cycles, then stays 1 -> no sw_db change during
//    the bounce. sw_db[0]=1 six edges after the final rise.
//  4 Glitch: 3-cycle pulse on bit15 (shorter than DB_CYCLES) -> sw_db and sw_chg never
//    change.
//  5 Reset mid-count: bit3 high for 3 cycles, then rst_n pulse low -> sw_db=0. After
//    release with bit3 still high, sw_db[3]=1 exactly 6 edges after release.
//  6 SW_HOLD_EN: hold=1, sw_raw=16'h1234 for 20 cycles -> sw_db unchanged. Drop hold ->
//    sw_db=16'h1234 after 4 edges, with a single sw_chg pulse.

Source files
------------

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - two-flop synchroniser plus per-bit debounce for board switches; SW_HOLD_EN adds the hold input
module sw_debounce #(
   parameter int WIDTH     = 16,
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef SW_HOLD_EN
   input  logic             hold,
`endif
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_db,
   output logic             sw_chg
);

   localparam int               CNT_W    = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] s2;
   logic [CNT_W-1:0] cnt     [WIDTH];
   logic [CNT_W-1:0] cnt_nxt [WIDTH];
   logic [WIDTH-1:0] upd;
   logic             hold_i;

`ifdef SW_HOLD_EN
   assign hold_i = hold;
`else
   assign hold_i = 1'b0;
`endif

   // two-stage synchroniser, nothing between the stages
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= sw_raw;
         s2 <= s1;
      end
   end

   // per-bit count of consecutive cycles the synchronised level differs from sw_db;
   // the last count position accepts the new level instead of incrementing, so the
   // counter tops out at DB_CYCLES-1 and cannot wrap
   always_comb begin
      upd = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_nxt[i] = '0;
         if (!hold_i && (s2[i] != sw_db[i])) begin
            if (cnt[i] == CNT_LAST) begin
               upd[i] = 1'b1;
            end else begin
               cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // counters, debounced value and the change pulse registered together
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
         sw_db  <= '0;
         sw_chg <= 1'b0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= cnt_nxt[i];
         end
         sw_db  <= sw_db ^ upd;
         sw_chg <= |upd;
      end
   end

endmodule
